hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl_if.sv | 32 +++
 rtl/hilo_ctrl.sv | 98 +++++++++
 tb/tb_hilo_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_if.sv
// HI/LO controller bus: MDU result strobe, direct MTHI/MTLO writes, reads and status.
interface hilo_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              ena;
    logic              op_start;
    logic              res_valid;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [DATA_W-1:0] wr_hi;
    logic [DATA_W-1:0] wr_lo;
    logic              rd_en;
    logic              rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              stall;
    logic              err;

    modport master (
        output ena, op_start, res_valid, res_hi, res_lo,
               wr_en, wr_sel, wr_hi, wr_lo, rd_en, rd_sel,
        input  rd_data, busy, stall, err
    );

    modport slave (
        input  ena, op_start, res_valid, res_hi, res_lo,
               wr_en, wr_sel, wr_hi, wr_lo, rd_en, rd_sel,
        output rd_data, busy, stall, err
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register controller with MDU busy tracking, latency watchdog and sticky error flag.
// Optional result forwarding on reads while BUSY is enabled by defining HILO_BYPASS_EN.
module hilo_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MAX_LAT = 40
) (
    input  logic       clk,
    input  logic       rst,
    hilo_ctrl_if.slave bus
);
    localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              err_q, err_d;
    logic              busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.wr_en) begin
                        case (bus.wr_sel)
                            2'b00:   lo_d = bus.wr_lo;
                            2'b11:   hi_d = bus.wr_hi;
                            2'b01: begin
                                hi_d = bus.wr_hi;
                                lo_d = bus.wr_lo;
                            end
                            default: ;
                        endcase
                    end
                    if (bus.res_valid) err_d = 1'b1;
                    if (bus.op_start) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                    end
                end
                ST_BUSY: begin
                    // Writes are refused here; a result always wins over a write.
                    if (bus.op_start) err_d = 1'b1;
                    if (bus.res_valid) begin
                        hi_d    = bus.res_hi;
                        lo_d    = bus.res_lo;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_W'(MAX_LAT - 1)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign bus.busy = busy;
    assign bus.err  = err_q;

`ifdef HILO_BYPASS_EN
    logic fwd;
    assign fwd         = busy && bus.res_valid;
    assign bus.rd_data = bus.rd_sel ? (fwd ? bus.res_hi : hi_q)
                                    : (fwd ? bus.res_lo : lo_q);
    assign bus.stall   = busy && (bus.wr_en || (bus.rd_en && !bus.res_valid));
`else
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
    assign bus.stall   = busy && (bus.rd_en || bus.wr_en);
`endif
endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed table-driven bench for hilo_ctrl plus hand sequences for watchdog, busy-error and reset abort.
module tb_hilo_ctrl;
    localparam int DW = 32;
`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    hilo_ctrl_if #(.DATA_W(DW)) bus ();

    hilo_ctrl #(.DATA_W(DW), .MAX_LAT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ena, op, rv;
        logic [DW-1:0] rhi, rlo;
        logic          we;
        logic [1:0]    ws;
        logic [DW-1:0] whi, wlo;
        logic          re, rs;
        logic [DW-1:0] e_rd;
        logic          e_busy, e_stall, e_err;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic ena, op, rv, input logic [DW-1:0] rhi, rlo,
                                input logic we, input logic [1:0] ws, input logic [DW-1:0] whi, wlo,
                                input logic re, rs, input logic [DW-1:0] e_rd,
                                input logic e_busy, e_stall, e_err);
        vec_t v;
        v.ena = ena; v.op = op; v.rv = rv; v.rhi = rhi; v.rlo = rlo;
        v.we = we; v.ws = ws; v.whi = whi; v.wlo = wlo; v.re = re; v.rs = rs;
        v.e_rd = e_rd; v.e_busy = e_busy; v.e_stall = e_stall; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ena = v.ena; bus.op_start = v.op; bus.res_valid = v.rv;
        bus.res_hi = v.rhi; bus.res_lo = v.rlo;
        bus.wr_en = v.we; bus.wr_sel = v.ws; bus.wr_hi = v.whi; bus.wr_lo = v.wlo;
        bus.rd_en = v.re; bus.rd_sel = v.rs;
    endtask

    task automatic idle_in();
        bus.ena = 1'b1; bus.op_start = 1'b0; bus.res_valid = 1'b0;
        bus.res_hi = '0; bus.res_lo = '0;
        bus.wr_en = 1'b0; bus.wr_sel = 2'b10; bus.wr_hi = '0; bus.wr_lo = '0;
        bus.rd_en = 1'b0; bus.rd_sel = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic read_hilo(input string tag, input logic [DW-1:0] e_hi, input logic [DW-1:0] e_lo);
        bus.rd_sel = 1'b1;
        #1;
        chk({tag, " HI"}, bus.rd_data, e_hi);
        bus.rd_sel = 1'b0;
        #1;
        chk({tag, " LO"}, bus.rd_data, e_lo);
    endtask

    initial begin
        int  n;
        bit  done;

        // ena op rv rhi rlo we ws whi wlo re rs | rd busy stall err
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'h0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,2'b01,32'hDEADBEEF,32'h12345678, 0,1, 32'h0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'hDEADBEEF,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h12345678,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,2'b11,32'hCAFEF00D,32'h11111111, 0,0, 32'h12345678,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'hCAFEF00D,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h12345678,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,2'b00,32'h0,32'h0BADC0DE, 0,0, 32'h12345678,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 1,2'b10,32'hFFFFFFFF,32'hFFFFFFFF, 0,1, 32'hCAFEF00D,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'hCAFEF00D,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,0,0,0));
        // ena=0: write, op_start and stray result are all ignored
        vq.push_back(mk(0,1,1,32'h9,32'h9, 1,2'b01,32'h1,32'h2, 0,0, 32'h0BADC0DE,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,0,0,0));
        // op_start, 5 busy cycles, result on the 6th
        vq.push_back(mk(1,1,0,0,0, 0,2'b10,0,0, 0,1, 32'hCAFEF00D,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 1,1, 32'hCAFEF00D,1,1,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 1,0, 32'h0BADC0DE,1,1,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,1,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,1,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0BADC0DE,1,0,0));
        vq.push_back(mk(1,0,1,32'h1,32'hFFFFFFFE, 0,2'b10,0,0, 1,0,
                        BYP ? 32'hFFFFFFFE : 32'h0BADC0DE, 1, BYP ? 1'b0 : 1'b1, 0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'h1,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'hFFFFFFFE,0,0,0));
        // write colliding with result in BUSY: result wins
        vq.push_back(mk(1,1,0,0,0, 0,2'b10,0,0, 0,1, 32'h1,0,0,0));
        vq.push_back(mk(1,0,1,32'hAAAA0000,32'h0000BBBB, 1,2'b01,32'h5,32'h6, 0,1,
                        BYP ? 32'hAAAA0000 : 32'h1, 1,1,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'hAAAA0000,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0000BBBB,0,0,0));
        // stray result in IDLE sets err, registers untouched
        vq.push_back(mk(1,0,1,32'hFFFF,32'hFFFF, 0,2'b10,0,0, 0,0, 32'h0000BBBB,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,0, 32'h0000BBBB,0,0,1));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'hAAAA0000,0,0,1));
        // read in the result cycle (forwarded when bypass is built in)
        vq.push_back(mk(1,1,0,0,0, 0,2'b10,0,0, 0,0, 32'h0000BBBB,0,0,1));
        vq.push_back(mk(1,0,1,32'h5A5A5A5A,32'hA5A5A5A5, 0,2'b10,0,0, 1,0,
                        BYP ? 32'hA5A5A5A5 : 32'h0000BBBB, 1, BYP ? 1'b0 : 1'b1, 1));
        vq.push_back(mk(1,0,0,0,0, 0,2'b10,0,0, 0,1, 32'h5A5A5A5A,0,0,1));

        idle_in();
        rst = 1'b0;
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_data", bus.rd_data, '0);
        chk("reset busy", DW'(bus.busy), '0);
        chk("reset stall", DW'(bus.stall), '0);
        chk("reset err", DW'(bus.err), '0);
        rst = 1'b1;
        idle_in();

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clk);
            chk($sformatf("v%0d rd_data", i), bus.rd_data, vq[i].e_rd);
            chk($sformatf("v%0d busy", i), DW'(bus.busy), DW'(vq[i].e_busy));
            chk($sformatf("v%0d stall", i), DW'(bus.stall), DW'(vq[i].e_stall));
            chk($sformatf("v%0d err", i), DW'(bus.err), DW'(vq[i].e_err));
            step();
        end

        // Watchdog with 3 disabled cycles mid-BUSY: 8 enabled + 3 frozen = 11 busy cycles
        do_reset();
        chk("wd reset err", DW'(bus.err), '0);
        bus.wr_en = 1'b1; bus.wr_sel = 2'b01; bus.wr_hi = 32'h13579BDF; bus.wr_lo = 32'h2468ACE0;
        step();
        idle_in();
        bus.op_start = 1'b1;
        step();
        idle_in();
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            bus.ena = !(k >= 2 && k < 5);
            @(negedge clk);
            if (bus.busy) begin
                n++;
                if (k == 9) chk("wd err before expiry", DW'(bus.err), '0);
                step();
            end else begin
                done = 1'b1;
            end
        end
        idle_in();
        chk("wd busy cycles", DW'(n), DW'(11));
        chk("wd busy after", DW'(bus.busy), '0);
        chk("wd err", DW'(bus.err), DW'(1));
        read_hilo("wd", 32'h13579BDF, 32'h2468ACE0);

        // op_start while BUSY sets err; operation continues and completes
        do_reset();
        bus.op_start = 1'b1;
        step();
        @(negedge clk);
        chk("ob err pre", DW'(bus.err), '0);
        @(posedge clk); #1;
        idle_in();
        chk("ob err", DW'(bus.err), DW'(1));
        chk("ob still busy", DW'(bus.busy), DW'(1));
        bus.res_valid = 1'b1; bus.res_hi = 32'h77; bus.res_lo = 32'h88;
        step();
        idle_in();
        chk("ob busy done", DW'(bus.busy), '0);
        read_hilo("ob", 32'h77, 32'h88);

        // Asynchronous reset mid-BUSY, then a late result is a protocol error
        do_reset();
        bus.op_start = 1'b1;
        step();
        idle_in();
        step();
        chk("ra busy", DW'(bus.busy), DW'(1));
        rst = 1'b0;
        #1;
        chk("ra async busy", DW'(bus.busy), '0);
        chk("ra async err", DW'(bus.err), '0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.res_valid = 1'b1; bus.res_hi = 32'h55; bus.res_lo = 32'h66;
        step();
        idle_in();
        chk("ra busy after", DW'(bus.busy), '0);
        chk("ra err", DW'(bus.err), DW'(1));
        read_hilo("ra", '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
